// File: rtl/dsp_mac_slice_param.sv
// dsp_mac_slice_param: signed pre-adder / multiplier / post-adder slice with
// configurable operand widths and pipeline depth. The opmode, C operand, the
// selected carry and a valid bit travel with each sample, so the mode can change
// on every cycle. The P stage adds saturation, overflow/underflow flags and
// pattern detect. PCIN/PCOUT allow slices to be chained.
module dsp_mac_slice_param #(
    parameter int                 A_WIDTH    = 18,
    parameter int                 B_WIDTH    = 18,
    parameter int                 P_WIDTH    = 48,
    parameter int                 IN_STAGES  = 1,
    parameter int                 MREG       = 1,
    parameter                     CARRYINSEL = "OPMODE5",
    parameter int                 SATURATE   = 0,
    parameter logic [P_WIDTH-1:0] PATTERN    = '0,
    parameter logic [P_WIDTH-1:0] MASK       = '1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CE,
    input  logic                       IN_VALID,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    input  logic [B_WIDTH-1:0]         D,
    input  logic [P_WIDTH-1:0]         C,
    input  logic [P_WIDTH-1:0]         PCIN,
    input  logic                       CARRYIN,
    input  logic [7:0]                 OPMODE,
    output logic                       OUT_VALID,
    output logic [A_WIDTH+B_WIDTH:0]   M,
    output logic [P_WIDTH-1:0]         P,
    output logic [P_WIDTH-1:0]         PCOUT,
    output logic                       CARRYOUT,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW,
    output logic                       PATTERNDETECT
);

    localparam int  MW      = A_WIDTH + B_WIDTH + 1;
    localparam int  FW      = P_WIDTH + 2;
    localparam int  UW      = P_WIDTH + 1;
    localparam bit  USE_CIN = (CARRYINSEL == "CARRYIN");

    localparam logic [FW-1:0]      FULL_MAX = {3'b000, {(P_WIDTH-1){1'b1}}};
    localparam logic [FW-1:0]      FULL_MIN = {3'b111, {(P_WIDTH-1){1'b0}}};
    localparam logic [P_WIDTH-1:0] P_MAX    = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] P_MIN    = {1'b1, {(P_WIDTH-1){1'b0}}};

    // Everything a sample needs, bundled so the input stages shift it as one word.
    typedef struct packed {
        logic               valid;
        logic [7:0]         opmode;
        logic               carryin;
        logic [P_WIDTH-1:0] c;
        logic [B_WIDTH-1:0] d;
        logic [B_WIDTH-1:0] b;
        logic [A_WIDTH-1:0] a;
    } in_t;

    // After the multiplier only the post-adder controls are still needed:
    // opmode bits [7] and [3:0], the already selected carry, C and the product.
    typedef struct packed {
        logic               valid;
        logic               sub;
        logic [3:0]         xz_sel;
        logic               cin;
        logic [P_WIDTH-1:0] c;
        logic [MW-1:0]      prod;
    } m_t;

    in_t in_raw;
    in_t in_s;
    m_t  m_raw;
    m_t  m_s;

    assign in_raw = {IN_VALID, OPMODE, CARRYIN, C, D, B, A};

    generate
        if (IN_STAGES == 0) begin : g_in_none
            assign in_s = in_raw;
        end else begin : g_in_regs
            in_t in_pipe [IN_STAGES];

            // Shift the input bundle through IN_STAGES registers.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < IN_STAGES; i++) in_pipe[i] <= '0;
                end else if (CE) begin
                    in_pipe[0] <= in_raw;
                    for (int i = 1; i < IN_STAGES; i++) in_pipe[i] <= in_pipe[i-1];
                end
            end

            assign in_s = in_pipe[IN_STAGES-1];
        end
    endgenerate

    logic [B_WIDTH:0] b_ext;
    logic [B_WIDTH:0] d_ext;
    logic [B_WIDTH:0] pre;
    logic [MW-1:0]    prod;
    logic             cin_sel;

    assign b_ext = {in_s.b[B_WIDTH-1], in_s.b};
    assign d_ext = {in_s.d[B_WIDTH-1], in_s.d};

    // Pre-adder: pass B, D+B or D-B, one bit wider than the operands.
    always_comb begin
        pre = b_ext;
        if (in_s.opmode[4]) begin
            pre = in_s.opmode[6] ? (d_ext - b_ext) : (d_ext + b_ext);
        end
    end

    // Both operands are sign-extended to the product width, so the low MW bits
    // of the product are the correct signed result.
    assign prod    = MW'($signed(pre)) * MW'($signed(in_s.a));
    assign cin_sel = USE_CIN ? in_s.carryin : in_s.opmode[5];
    assign m_raw   = {in_s.valid, in_s.opmode[7], in_s.opmode[3:0], cin_sel, in_s.c, prod};

    generate
        if (MREG == 0) begin : g_m_none
            assign m_s = m_raw;
        end else begin : g_m_reg
            m_t m_q;

            // Product register, with the sample's post-adder controls alongside.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    m_q <= '0;
                end else if (CE) begin
                    m_q <= m_raw;
                end
            end

            assign m_s = m_q;
        end
    endgenerate

    logic [P_WIDTH-1:0] m_ext;
    logic [P_WIDTH-1:0] x_mux;
    logic [P_WIDTH-1:0] z_mux;

    assign m_ext = P_WIDTH'($signed(m_s.prod));

    // X operand select.
    always_comb begin
        x_mux = '0;
        case (m_s.xz_sel[1:0])
            2'b00:   x_mux = '0;
            2'b01:   x_mux = m_ext;
            2'b10:   x_mux = P;
            default: x_mux = m_s.c;
        endcase
    end

    // Z operand select.
    always_comb begin
        z_mux = '0;
        case (m_s.xz_sel[3:2])
            2'b00:   z_mux = '0;
            2'b01:   z_mux = PCIN;
            2'b10:   z_mux = P;
            default: z_mux = m_s.c;
        endcase
    end

    logic [FW-1:0]      x_f;
    logic [FW-1:0]      z_f;
    logic [FW-1:0]      full;
    logic [UW-1:0]      x_u;
    logic [UW-1:0]      z_u;
    logic               co_next;
    logic [P_WIDTH-1:0] sum_low_unused;
    logic               ovf_next;
    logic               unf_next;
    logic [P_WIDTH-1:0] p_next;
    logic               pd_next;

    assign x_f = FW'($signed(x_mux));
    assign z_f = FW'($signed(z_mux));
    assign x_u = {1'b0, x_mux};
    assign z_u = {1'b0, z_mux};

    // Signed result wide enough that it can never wrap, plus the unsigned
    // carry/borrow of the P_WIDTH-bit operation.
    always_comb begin
        if (m_s.sub) begin
            full                      = z_f - x_f - FW'(m_s.cin);
            {co_next, sum_low_unused} = z_u - x_u - UW'(m_s.cin);
        end else begin
            full                      = z_f + x_f + FW'(m_s.cin);
            {co_next, sum_low_unused} = z_u + x_u + UW'(m_s.cin);
        end
    end

    assign ovf_next = $signed(full) > $signed(FULL_MAX);
    assign unf_next = $signed(full) < $signed(FULL_MIN);

    // Clamp only when saturation is enabled; otherwise wrap modulo 2^P_WIDTH.
    always_comb begin
        p_next = full[P_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (ovf_next)      p_next = P_MAX;
            else if (unf_next) p_next = P_MIN;
        end
    end

    assign pd_next = (((p_next ^ PATTERN) & ~MASK) == '0);

    // P stage: the valid bit advances on every enabled cycle, the result and
    // flags load only for a valid sample so bubbles leave the accumulator alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID     <= 1'b0;
            P             <= '0;
            CARRYOUT      <= 1'b0;
            OVERFLOW      <= 1'b0;
            UNDERFLOW     <= 1'b0;
            PATTERNDETECT <= 1'b0;
        end else if (CE) begin
            OUT_VALID <= m_s.valid;
            if (m_s.valid) begin
                P             <= p_next;
                CARRYOUT      <= co_next;
                OVERFLOW      <= ovf_next;
                UNDERFLOW     <= unf_next;
                PATTERNDETECT <= pd_next;
            end
        end
    end

    assign M     = m_s.prod;
    assign PCOUT = P;

endmodule

// File: tb/tb_dsp_mac_slice_param.sv
// Directed bench for dsp_mac_slice_param: four instances share one stimulus
// (default, saturating, pattern-detect, and a zero-pipeline CARRYIN variant).
module tb_dsp_mac_slice_param;

    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 48;
    localparam int MW = AW + BW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          in_valid;
    logic          carryin;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] d;
    logic [PW-1:0] c;
    logic [PW-1:0] pcin;
    logic [7:0]    opmode;

    logic d_ov, d_co, d_of, d_uf, d_pd;
    logic [MW-1:0] d_m;
    logic [PW-1:0] d_p, d_pc;
    logic s_ov, s_co, s_of, s_uf, s_pd;
    logic [MW-1:0] s_m;
    logic [PW-1:0] s_p, s_pc;
    logic t_ov, t_co, t_of, t_uf, t_pd;
    logic [MW-1:0] t_m;
    logic [PW-1:0] t_p, t_pc;
    logic l_ov, l_co, l_of, l_uf, l_pd;
    logic [MW-1:0] l_m;
    logic [PW-1:0] l_p, l_pc;

    int n_chk = 0;
    int n_err = 0;

    int acc_iv [7] = '{1, 1, 0, 1, 1, 0, 0};
    int acc_ov [7] = '{0, 0, 1, 1, 0, 1, 1};
    int acc_p  [7] = '{0, 0, 10, 20, 20, 30, 40};

    always #5 clk = ~clk;

    dsp_mac_slice_param u_def (
        .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
        .PCIN(pcin), .CARRYIN(carryin), .OPMODE(opmode), .OUT_VALID(d_ov), .M(d_m), .P(d_p),
        .PCOUT(d_pc), .CARRYOUT(d_co), .OVERFLOW(d_of), .UNDERFLOW(d_uf), .PATTERNDETECT(d_pd)
    );

    dsp_mac_slice_param #(.SATURATE(1)) u_sat (
        .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
        .PCIN(pcin), .CARRYIN(carryin), .OPMODE(opmode), .OUT_VALID(s_ov), .M(s_m), .P(s_p),
        .PCOUT(s_pc), .CARRYOUT(s_co), .OVERFLOW(s_of), .UNDERFLOW(s_uf), .PATTERNDETECT(s_pd)
    );

    dsp_mac_slice_param #(.PATTERN(48'd5), .MASK(48'd0)) u_pat (
        .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
        .PCIN(pcin), .CARRYIN(carryin), .OPMODE(opmode), .OUT_VALID(t_ov), .M(t_m), .P(t_p),
        .PCOUT(t_pc), .CARRYOUT(t_co), .OVERFLOW(t_of), .UNDERFLOW(t_uf), .PATTERNDETECT(t_pd)
    );

    dsp_mac_slice_param #(.IN_STAGES(0), .MREG(0), .CARRYINSEL("CARRYIN")) u_l1 (
        .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
        .PCIN(pcin), .CARRYIN(carryin), .OPMODE(opmode), .OUT_VALID(l_ov), .M(l_m), .P(l_p),
        .PCOUT(l_pc), .CARRYOUT(l_co), .OVERFLOW(l_of), .UNDERFLOW(l_uf), .PATTERNDETECT(l_pd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_and_wait3();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; carryin = 1'b0;
        a = '0; b = '0; d = '0; c = '0; pcin = '0; opmode = '0;
        tick();
        tick();
        chk("reset_p", 64'(d_p), 64'd0);
        chk("reset_m", 64'(d_m), 64'd0);
        chk("reset_valid", 64'(d_ov), 64'd0);
        chk("reset_flags", 64'({d_co, d_of, d_uf, d_pd}), 64'd0);
        rst = 1'b0;

        // single product, default latency 3, and the L=1 CARRYIN variant
        a = 18'd3; b = 18'd4; opmode = 8'h01; carryin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("l1_valid_e1", 64'(l_ov), 64'd1);
        chk("l1_p_carryin", 64'(l_p), 64'd13);
        chk("def_valid_e1", 64'(d_ov), 64'd0);
        tick();
        chk("def_valid_e2", 64'(d_ov), 64'd0);
        chk("l1_valid_e2", 64'(l_ov), 64'd0);
        tick();
        chk("def_valid_e3", 64'(d_ov), 64'd1);
        chk("def_p", 64'(d_p), 64'd12);
        chk("def_m", 64'(d_m), 64'd12);
        chk("def_pcout", 64'(d_pc), 64'd12);
        chk("def_flags", 64'({d_co, d_of, d_uf}), 64'd0);
        chk("def_pd_mask_all", 64'(d_pd), 64'd1);
        tick();
        chk("def_valid_e4", 64'(d_ov), 64'd0);
        chk("def_p_hold", 64'(d_p), 64'd12);

        // accumulate with a bubble
        carryin = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_p", 64'(d_p), 64'd0);
        rst = 1'b0;
        opmode = 8'h09; a = 18'd2; b = 18'd5;
        for (int k = 0; k < 7; k++) begin
            in_valid = acc_iv[k][0];
            tick();
            chk($sformatf("acc_valid_%0d", k), 64'(d_ov), 64'(acc_ov[k]));
            chk($sformatf("acc_p_%0d", k), 64'(d_p), 64'(acc_p[k]));
        end
        in_valid = 1'b0;

        // pre-subtract D-B with negative A
        opmode = 8'h51; d = 18'd10; b = 18'd3; a = -18'sd2;
        pulse_and_wait3();
        chk("presub_valid", 64'(d_ov), 64'd1);
        chk("presub_p", 64'(d_p), 64'hFFFF_FFFF_FFF2);
        chk("presub_m", 64'(d_m), 64'h1F_FFFF_FFF2);
        chk("presub_flags", 64'({d_co, d_of, d_uf}), 64'd0);

        // overflow: saturate vs wrap
        opmode = 8'h0D; c = 48'h7FFF_FFFF_FFFF; a = 18'd1; b = 18'd1;
        pulse_and_wait3();
        chk("sat_ovf_p", 64'(s_p), 64'h7FFF_FFFF_FFFF);
        chk("sat_ovf_flag", 64'(s_of), 64'd1);
        chk("wrap_ovf_p", 64'(d_p), 64'h8000_0000_0000);
        chk("wrap_ovf_flag", 64'({d_of, d_uf}), 64'b10);

        // underflow: C - M with C at the signed minimum
        opmode = 8'h8D; c = 48'h8000_0000_0000;
        pulse_and_wait3();
        chk("sat_unf_p", 64'(s_p), 64'h8000_0000_0000);
        chk("sat_unf_flags", 64'({s_of, s_uf}), 64'b01);
        chk("wrap_unf_p", 64'(d_p), 64'h7FFF_FFFF_FFFF);
        chk("wrap_unf_flags", 64'({d_of, d_uf}), 64'b01);

        // unsigned carry out: -1 + 1
        opmode = 8'h0D; c = '1;
        pulse_and_wait3();
        chk("carry_p", 64'(d_p), 64'd0);
        chk("carry_out", 64'(d_co), 64'd1);
        chk("carry_flags", 64'({d_of, d_uf}), 64'd0);

        // cascade input on Z
        opmode = 8'h05; pcin = 48'd100;
        pulse_and_wait3();
        chk("pcin_p", 64'(d_p), 64'd101);
        chk("pcin_co", 64'(d_co), 64'd0);

        // clock-enable stall of two cycles
        opmode = 8'h01; a = 18'd5; b = 18'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; ce = 1'b0;
        tick();
        chk("stall_valid_e2", 64'(d_ov), 64'd0);
        tick();
        chk("stall_valid_e3", 64'(d_ov), 64'd0);
        chk("stall_p_frozen", 64'(d_p), 64'd101);
        ce = 1'b1;
        tick();
        chk("stall_valid_e4", 64'(d_ov), 64'd0);
        tick();
        chk("stall_valid_e5", 64'(d_ov), 64'd1);
        chk("stall_p", 64'(d_p), 64'd30);
        tick();
        chk("stall_valid_once", 64'(d_ov), 64'd0);

        // reset in the middle of accumulation
        opmode = 8'h09; a = 18'd2; b = 18'd5; in_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("midacc_p1", 64'(d_p), 64'd40);
        tick();
        chk("midacc_p2", 64'(d_p), 64'd50);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("midrst_p", 64'(d_p), 64'd0);
        chk("midrst_valid", 64'(d_ov), 64'd0);
        chk("midrst_m", 64'(d_m), 64'd0);
        tick();
        rst = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("postrst_no_stale", 64'(d_ov), 64'd0);
        tick();
        chk("postrst_valid", 64'(d_ov), 64'd1);
        chk("postrst_p", 64'(d_p), 64'd10);

        // pattern detect on a counting accumulator
        rst = 1'b1;
        #1;
        rst = 1'b0;
        opmode = 8'h28; in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("pat_p_%0d", k), 64'(t_p), (k >= 3) ? 64'(k - 2) : 64'd0);
            chk($sformatf("pat_pd_%0d", k), 64'(t_pd), (k == 7) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
